// File: rtl/vending_pkg.sv
// Shared coin codes, nickel-unit coin values and FSM state encoding for the
// change-returning newspaper vending block.
package vending_pkg;

    localparam logic [1:0] COIN_NONE    = 2'b00;
    localparam logic [1:0] COIN_NICKEL  = 2'b01;
    localparam logic [1:0] COIN_DIME    = 2'b10;
    localparam logic [1:0] COIN_QUARTER = 2'b11;

    localparam logic [2:0] VAL_NONE    = 3'd0;
    localparam logic [2:0] VAL_NICKEL  = 3'd1;
    localparam logic [2:0] VAL_DIME    = 3'd2;
    localparam logic [2:0] VAL_QUARTER = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2
    } state_e;

endpackage

// File: rtl/vending_coin_detect.sv
// Turns the level-coded coin slot into single-cycle coin events with a
// nickel-unit value; a disabled quarter is flagged as a bad event.
module vending_coin_detect
    import vending_pkg::*;
#(
    parameter int QUARTER_EN = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] coin_i,
    output logic       coin_evt_o,
    output logic [2:0] coin_val_o,
    output logic       coin_bad_o
);

    logic [1:0] coin_q;

    // Resetting to "quarter present" means a coin held through reset release
    // must be removed before it can count.
    always_ff @(posedge clock) begin
        if (!reset) begin
            coin_q <= COIN_QUARTER;
        end else begin
            coin_q <= coin_i;
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        coin_evt_o = (coin_i != COIN_NONE) && (coin_q == COIN_NONE);
        coin_val_o = VAL_NONE;
        coin_bad_o = 1'b0;
        case (coin_i)
            COIN_NICKEL:  coin_val_o = VAL_NICKEL;
            COIN_DIME:    coin_val_o = VAL_DIME;
            COIN_QUARTER: begin
                if (QUARTER_EN != 0) begin
                    coin_val_o = VAL_QUARTER;
                end else begin
                    coin_bad_o = coin_evt_o;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/vending_change_fsm.sv
// Credit accumulation, single vend pulse and nickel-by-nickel change return;
// every output is a register or a decode of the state register.
module vending_change_fsm
    import vending_pkg::*;
#(
    parameter int PRICE_UNITS = 3,
    parameter int CREDIT_W    = 4,
    parameter int QUARTER_EN  = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic                newspaper,
    output logic                change_nickel,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    localparam logic [CREDIT_W:0] PRICE_W = (CREDIT_W+1)'(PRICE_UNITS);

    logic          coin_evt;
    logic [2:0]    coin_val;
    logic          coin_bad;
    logic [CREDIT_W:0] sum_d;

    state_e              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic                newspaper_q;
    logic                change_q;
    logic                reject_q;

    vending_coin_detect #(
        .QUARTER_EN (QUARTER_EN)
    ) u_coin_detect (
        .clock      (clock),
        .reset      (reset),
        .coin_i     (coin),
        .coin_evt_o (coin_evt),
        .coin_val_o (coin_val),
        .coin_bad_o (coin_bad)
    );

    // One bit wider than credit so the compare against price never wraps.
    assign sum_d = {1'b0, credit_q} + (CREDIT_W+1)'(coin_val);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch reads the pre-edge values of state_q and credit_q.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            credit_q    <= '0;
            newspaper_q <= 1'b0;
            change_q    <= 1'b0;
            reject_q    <= 1'b0;
        end else begin
            newspaper_q <= 1'b0;
            change_q    <= 1'b0;
            reject_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cancel && (credit_q != '0)) begin
                        state_q  <= ST_CHANGE;
                        change_q <= 1'b1;
                        reject_q <= coin_evt;
                    end else if (coin_evt) begin
                        if (coin_bad) begin
                            reject_q <= 1'b1;
                        end else if (sum_d >= PRICE_W) begin
                            credit_q    <= CREDIT_W'(sum_d - PRICE_W);
                            state_q     <= ST_VEND;
                            newspaper_q <= 1'b1;
                        end else begin
                            credit_q <= CREDIT_W'(sum_d);
                        end
                    end
                end
                ST_VEND: begin
                    reject_q <= coin_evt;
                    if (credit_q != '0) begin
                        state_q  <= ST_CHANGE;
                        change_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CHANGE: begin
                    reject_q <= coin_evt;
                    credit_q <= credit_q - CREDIT_W'(1);
                    if (credit_q == CREDIT_W'(1)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        change_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign newspaper     = newspaper_q;
    assign change_nickel = change_q;
    assign coin_reject   = reject_q;
    assign busy          = (state_q != ST_IDLE);
    assign credit        = credit_q;

endmodule

// File: tb/tb_vending_change_fsm.sv
// Scoreboard bench: each driven cycle pushes its expected outputs, which are
// popped and compared one cycle later just after the clock edge.
module tb_vending_change_fsm;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] coin;
    logic       cancel;
    logic [1:0] coin2;
    logic       cancel2;

    logic       np1, cn1, rj1, by1;
    logic [3:0] cr1;
    logic       np2, cn2, rj2, by2;
    logic [3:0] cr2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic       np;
        logic       cn;
        logic       rj;
        logic       by;
        logic [3:0] cr;
    } exp_t;

    exp_t exp_q[$];

    always #5 clock = ~clock;

    vending_change_fsm #(
        .PRICE_UNITS (3),
        .CREDIT_W    (4),
        .QUARTER_EN  (1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .coin          (coin),
        .cancel        (cancel),
        .newspaper     (np1),
        .change_nickel (cn1),
        .coin_reject   (rj1),
        .busy          (by1),
        .credit        (cr1)
    );

    vending_change_fsm #(
        .PRICE_UNITS (3),
        .CREDIT_W    (4),
        .QUARTER_EN  (0)
    ) dut_nq (
        .clock         (clock),
        .reset         (reset),
        .coin          (coin2),
        .cancel        (cancel2),
        .newspaper     (np2),
        .change_nickel (cn2),
        .coin_reject   (rj2),
        .busy          (by2),
        .credit        (cr2)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // sel=0 drives/checks the quarter-enabled instance, sel=1 the other one.
    task automatic cyc(input bit sel, input logic rst, input logic [1:0] c, input logic can,
                       input string tag, input logic np, input logic cn, input logic rj,
                       input logic by, input logic [3:0] cr);
        exp_t e;
        @(negedge clock);
        reset = rst;
        if (sel) begin
            coin2 = c; cancel2 = can; coin = 2'b00; cancel = 1'b0;
        end else begin
            coin = c; cancel = can; coin2 = 2'b00; cancel2 = 1'b0;
        end
        e.tag = tag; e.np = np; e.cn = cn; e.rj = rj; e.by = by; e.cr = cr;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check({e.tag, ".newspaper"},     {7'b0, sel ? np2 : np1}, {7'b0, e.np});
        check({e.tag, ".change_nickel"}, {7'b0, sel ? cn2 : cn1}, {7'b0, e.cn});
        check({e.tag, ".coin_reject"},   {7'b0, sel ? rj2 : rj1}, {7'b0, e.rj});
        check({e.tag, ".busy"},          {7'b0, sel ? by2 : by1}, {7'b0, e.by});
        check({e.tag, ".credit"},        {4'b0, sel ? cr2 : cr1}, {4'b0, e.cr});
    endtask

    initial begin
        reset = 1'b0; coin = 2'b00; cancel = 1'b0; coin2 = 2'b00; cancel2 = 1'b0;
        //   sel rst coin  can  tag            np cn rj by cr
        cyc(0, 0, 2'b00, 0, "reset0",        0, 0, 0, 0, 0);
        cyc(0, 0, 2'b00, 0, "reset1",        0, 0, 0, 0, 0);
        cyc(0, 1, 2'b00, 0, "idle",          0, 0, 0, 0, 0);

        // three nickels at 15 cents
        cyc(0, 1, 2'b01, 0, "n1",            0, 0, 0, 0, 1);
        cyc(0, 1, 2'b01, 0, "n1_hold",       0, 0, 0, 0, 1);
        cyc(0, 1, 2'b00, 0, "n1_gap",        0, 0, 0, 0, 1);
        cyc(0, 1, 2'b01, 0, "n2",            0, 0, 0, 0, 2);
        cyc(0, 1, 2'b01, 0, "n2_hold",       0, 0, 0, 0, 2);
        cyc(0, 1, 2'b00, 0, "n2_gap",        0, 0, 0, 0, 2);
        cyc(0, 1, 2'b01, 0, "n3_vend",       1, 0, 0, 1, 0);
        cyc(0, 1, 2'b01, 0, "n3_after",      0, 0, 0, 0, 0);
        cyc(0, 1, 2'b00, 0, "n3_gap",        0, 0, 0, 0, 0);

        // quarter: vend then two nickels change
        cyc(0, 1, 2'b11, 0, "q_vend",        1, 0, 0, 1, 2);
        cyc(0, 1, 2'b00, 0, "q_chg1",        0, 1, 0, 1, 2);
        cyc(0, 1, 2'b00, 0, "q_chg2",        0, 1, 0, 1, 1);
        cyc(0, 1, 2'b00, 0, "q_idle",        0, 0, 0, 0, 0);

        // dime, dime: one nickel change
        cyc(0, 1, 2'b10, 0, "d1",            0, 0, 0, 0, 2);
        cyc(0, 1, 2'b00, 0, "d1_gap",        0, 0, 0, 0, 2);
        cyc(0, 1, 2'b10, 0, "d2_vend",       1, 0, 0, 1, 1);
        cyc(0, 1, 2'b00, 0, "d2_chg",        0, 1, 0, 1, 1);
        cyc(0, 1, 2'b00, 0, "d2_idle",       0, 0, 0, 0, 0);

        // cancel refund, cancel with no credit, cancel/coin collision
        cyc(0, 1, 2'b01, 0, "c_nick",        0, 0, 0, 0, 1);
        cyc(0, 1, 2'b00, 1, "c_refund",      0, 1, 0, 1, 1);
        cyc(0, 1, 2'b00, 0, "c_idle",        0, 0, 0, 0, 0);
        cyc(0, 1, 2'b00, 1, "c_empty",       0, 0, 0, 0, 0);
        cyc(0, 1, 2'b01, 0, "cc_nick",       0, 0, 0, 0, 1);
        cyc(0, 1, 2'b00, 0, "cc_gap",        0, 0, 0, 0, 1);
        cyc(0, 1, 2'b10, 1, "cc_collide",    0, 1, 1, 1, 1);
        cyc(0, 1, 2'b10, 0, "cc_idle",       0, 0, 0, 0, 0);
        cyc(0, 1, 2'b00, 0, "cc_gap2",       0, 0, 0, 0, 0);

        // coin held five cycles counts once
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 2'b01, 0, $sformatf("hold%0d", i), 0, 0, 0, 0, 1);
        end
        cyc(0, 1, 2'b00, 0, "hold_gap",      0, 0, 0, 0, 1);

        // dime during change is rejected, change continues
        cyc(0, 1, 2'b11, 0, "b_vend",        1, 0, 0, 1, 3);
        cyc(0, 1, 2'b00, 0, "b_chg1",        0, 1, 0, 1, 3);
        cyc(0, 1, 2'b10, 0, "b_dime_rej",    0, 1, 1, 1, 2);
        cyc(0, 1, 2'b00, 0, "b_chg3",        0, 1, 0, 1, 1);
        cyc(0, 1, 2'b00, 0, "b_idle",        0, 0, 0, 0, 0);

        // quarter disabled instance
        cyc(1, 1, 2'b00, 0, "nq_idle",       0, 0, 0, 0, 0);
        cyc(1, 1, 2'b11, 0, "nq_quarter",    0, 0, 1, 0, 0);
        cyc(1, 1, 2'b00, 0, "nq_gap",        0, 0, 0, 0, 0);
        cyc(1, 1, 2'b01, 0, "nq_nick",       0, 0, 0, 0, 1);
        cyc(1, 1, 2'b00, 0, "nq_gap2",       0, 0, 0, 0, 1);

        // reset during change, nickel held across reset release
        cyc(0, 1, 2'b11, 0, "r_vend",        1, 0, 0, 1, 2);
        cyc(0, 1, 2'b00, 0, "r_chg",         0, 1, 0, 1, 2);
        cyc(0, 0, 2'b01, 0, "r_reset",       0, 0, 0, 0, 0);
        cyc(0, 1, 2'b01, 0, "r_release",     0, 0, 0, 0, 0);
        cyc(0, 1, 2'b01, 0, "r_held",        0, 0, 0, 0, 0);
        cyc(0, 1, 2'b00, 0, "r_removed",     0, 0, 0, 0, 0);
        cyc(0, 1, 2'b01, 0, "r_reinsert",    0, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
